// File: rtl/led_pkg.sv
// Shared definitions for the LED up/down counter chain and its button front end.
package led_pkg;

    // Debouncer FSM state encoding; the counter blocks decode the same values.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for asynchronous board inputs. Depth and the
// reset level are parameters so the same block serves every pin.
module synchronizer
    import led_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_pipe;

    // Shift the raw pin through the chain; reset loads the inactive level so
    // no phantom edge appears after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_pipe <= {STAGES{RESET_VALUE}};
        end else begin
            sync_pipe <= {sync_pipe[STAGES-2:0], din};
        end
    end

    assign dout = sync_pipe[STAGES-1];

endmodule

// File: rtl/start_debouncer.sv
// Push-button front end for the LED counter chain: synchronises the raw pin,
// filters bounce with a stability counter, and emits one start (or dropped)
// pulse per debounced press.
module start_debouncer
    import led_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 12000,
    parameter logic ACTIVE_LEVEL    = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic busy,
    output logic start,
    output logic dropped,
    output logic pressed
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          sync_out;
    logic          level;
    db_state_t     state;
    logic [CW-1:0] cnt;

    synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (~ACTIVE_LEVEL)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (button),
        .dout  (sync_out)
    );

    // Normalise polarity so the FSM always treats 1 as "pressed".
    assign level = (sync_out == ACTIVE_LEVEL);

    // Debounce FSM with stability counter and registered pulse outputs.
    // A level change is accepted only after the counter has seen
    // DEBOUNCE_CYCLES-1 further stable samples; any reversal restarts it.
    // busy is looked at only on the accepting edge of a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            start   <= 1'b0;
            dropped <= 1'b0;
            pressed <= 1'b0;
        end else begin
            start   <= 1'b0;
            dropped <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    pressed <= 1'b0;
                    if (level) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!level) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= HELD;
                        cnt     <= '0;
                        pressed <= 1'b1;
                        start   <= ~busy;
                        dropped <= busy;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    cnt     <= '0;
                    pressed <= 1'b1;
                    if (!level) begin
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (level) begin
                        // Release was a glitch: back to HELD without a new pulse.
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule
